// File: rtl/rsa_regbank_pkg.sv
// Shared defaults and word/address types for the RSA ASIP register bank.
package rsa_regbank_pkg;

    localparam int unsigned ARQ_DEF  = 16;
    localparam int unsigned REGS_DEF = 8;
    localparam int unsigned AW_DEF   = $clog2(REGS_DEF);

    typedef logic [AW_DEF-1:0]  reg_addr_t;
    typedef logic [ARQ_DEF-1:0] word_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy scoreboard with read-after-write hazard detection.
import rsa_regbank_pkg::*;

module reg_scoreboard #(
    parameter int unsigned REGS = REGS_DEF,
    localparam int unsigned AW  = $clog2(REGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            write_en,
    input  logic [AW-1:0]   write_addr,
    input  logic            lock_en,
    input  logic [AW-1:0]   lock_addr,
    input  logic            read_en,
    input  logic [AW-1:0]   src1,
    input  logic [AW-1:0]   src2,
    input  logic [AW-1:0]   srcdest,
    output logic            stall,
    output logic [REGS-1:0] busy
);

    logic [REGS-1:0] busy_nxt;
    logic            pend1, pend2, pend3;

    // Next busy vector: a completing write releases its register, a lock
    // applied afterwards wins so a new producer on the same address stays busy.
    always_comb begin
        busy_nxt = busy;
        if (write_en) busy_nxt[write_addr] = 1'b0;
        if (lock_en)  busy_nxt[lock_addr]  = 1'b1;
    end

    // Scoreboard state; clr wipes every bit ahead of write/lock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     busy <= '0;
        else if (clr) busy <= '0;
        else          busy <= busy_nxt;
    end

    // A busy register being written this cycle is served by the bypass path.
    assign pend1 = busy[src1]    && !(write_en && (write_addr == src1));
    assign pend2 = busy[src2]    && !(write_en && (write_addr == src2));
    assign pend3 = busy[srcdest] && !(write_en && (write_addr == srcdest));

    assign stall = read_en && (pend1 || pend2 || pend3);

endmodule

// File: rtl/reg_bank_sb.sv
// Parametrised register bank: one write port, three registered read ports
// with write bypass, and a busy scoreboard for in-flight producers.
import rsa_regbank_pkg::*;

module reg_bank_sb #(
    parameter int unsigned ARQ  = ARQ_DEF,
    parameter int unsigned REGS = REGS_DEF,
    localparam int unsigned AW  = $clog2(REGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            write_en,
    input  logic [AW-1:0]   write_addr,
    input  logic [ARQ-1:0]  write_val,
    input  logic            lock_en,
    input  logic [AW-1:0]   lock_addr,
    input  logic            read_en,
    input  logic [AW-1:0]   src1,
    input  logic [AW-1:0]   src2,
    input  logic [AW-1:0]   srcdest,
    output logic [ARQ-1:0]  out1,
    output logic [ARQ-1:0]  out2,
    output logic [ARQ-1:0]  out3,
    output logic            rd_valid,
    output logic            stall,
    output logic [REGS-1:0] busy
);

    logic [ARQ-1:0] mem [REGS];
    logic [ARQ-1:0] byp1, byp2, byp3;
    logic           accept;

    reg_scoreboard #(
        .REGS (REGS)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .write_en   (write_en),
        .write_addr (write_addr),
        .lock_en    (lock_en),
        .lock_addr  (lock_addr),
        .read_en    (read_en),
        .src1       (src1),
        .src2       (src2),
        .srcdest    (srcdest),
        .stall      (stall),
        .busy       (busy)
    );

    // Storage array; clr has priority over a same-cycle write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < REGS; i++) mem[i] <= '0;
        end else if (clr) begin
            for (int unsigned i = 0; i < REGS; i++) mem[i] <= '0;
        end else if (write_en) begin
            mem[write_addr] <= write_val;
        end
    end

    // Same-cycle write data overrides stale array contents on each read port.
    always_comb begin
        byp1 = (write_en && (write_addr == src1))    ? write_val : mem[src1];
        byp2 = (write_en && (write_addr == src2))    ? write_val : mem[src2];
        byp3 = (write_en && (write_addr == srcdest)) ? write_val : mem[srcdest];
    end

    assign accept = read_en && !stall;

    // Output registers: capture on an accepted read, otherwise hold.
    // clr suppresses the capture but leaves the held values untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out1     <= '0;
            out2     <= '0;
            out3     <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= accept && !clr;
            if (accept && !clr) begin
                out1 <= byp1;
                out2 <= byp2;
                out3 <= byp3;
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_sb.sv
// Scoreboard-style bench for reg_bank_sb: stimulus pushes expected read
// results, per-instance monitors pop and compare whenever rd_valid is seen.
module tb_reg_bank_sb;

    typedef struct packed {
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] e3;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default 16-bit x 8 registers
    logic        a_rst, a_clr, a_we, a_le, a_re;
    logic [2:0]  a_wa, a_la, a_s1, a_s2, a_s3;
    logic [15:0] a_wv, a_o1, a_o2, a_o3;
    logic        a_rv, a_st;
    logic [7:0]  a_busy;

    // Instance B: 32-bit x 16 registers
    logic        b_rst, b_clr, b_we, b_le, b_re;
    logic [3:0]  b_wa, b_la, b_s1, b_s2, b_s3;
    logic [31:0] b_wv, b_o1, b_o2, b_o3;
    logic        b_rv, b_st;
    logic [15:0] b_busy;

    reg_bank_sb u_a (
        .clk(clk), .rst(a_rst), .clr(a_clr),
        .write_en(a_we), .write_addr(a_wa), .write_val(a_wv),
        .lock_en(a_le), .lock_addr(a_la),
        .read_en(a_re), .src1(a_s1), .src2(a_s2), .srcdest(a_s3),
        .out1(a_o1), .out2(a_o2), .out3(a_o3),
        .rd_valid(a_rv), .stall(a_st), .busy(a_busy)
    );

    reg_bank_sb #(.ARQ(32), .REGS(16)) u_b (
        .clk(clk), .rst(b_rst), .clr(b_clr),
        .write_en(b_we), .write_addr(b_wa), .write_val(b_wv),
        .lock_en(b_le), .lock_addr(b_la),
        .read_en(b_re), .src1(b_s1), .src2(b_s2), .srcdest(b_s3),
        .out1(b_o1), .out2(b_o2), .out3(b_o3),
        .rd_valid(b_rv), .stall(b_st), .busy(b_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Monitor A
    always @(posedge clk) begin
        #1;
        if (a_rv === 1'b1) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_valid: got rd_valid=1 expected 0");
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_out1", {16'h0, a_o1}, e.e1);
                chk("a_out2", {16'h0, a_o2}, e.e2);
                chk("a_out3", {16'h0, a_o3}, e.e3);
            end
        end
    end

    // Monitor B
    always @(posedge clk) begin
        #1;
        if (b_rv === 1'b1) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_valid: got rd_valid=1 expected 0");
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_out1", b_o1, e.e1);
                chk("b_out2", b_o2, e.e2);
                chk("b_out3", b_o3, e.e3);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst = 1'b0; a_clr = 1'b0; a_we = 1'b0; a_le = 1'b0; a_re = 1'b0;
        a_wa = '0; a_la = '0; a_s1 = '0; a_s2 = '0; a_s3 = '0; a_wv = '0;
        b_rst = 1'b0; b_clr = 1'b0; b_we = 1'b0; b_le = 1'b0; b_re = 1'b0;
        b_wa = '0; b_la = '0; b_s1 = '0; b_s2 = '0; b_s3 = '0; b_wv = '0;

        tick(); tick();
        chk("a_reset_out1", {16'h0, a_o1}, 32'h0);
        chk("a_reset_out2", {16'h0, a_o2}, 32'h0);
        chk("a_reset_out3", {16'h0, a_o3}, 32'h0);
        chk("a_reset_rv", {31'h0, a_rv}, 32'h0);
        chk("a_reset_busy", {24'h0, a_busy}, 32'h0);
        a_rst = 1'b1;
        b_rst = 1'b1;

        // Basic writes then three-port read
        a_we = 1'b1; a_wa = 3'd1; a_wv = 16'd150; tick();
        a_wa = 3'd0; a_wv = 16'd144; tick();
        a_wa = 3'd2; a_wv = 16'd145; tick();
        a_we = 1'b0;
        a_re = 1'b1; a_s1 = 3'd0; a_s2 = 3'd1; a_s3 = 3'd2;
        settle();
        chk("a_basic_stall", {31'h0, a_st}, 32'h0);
        qa.push_back('{32'd144, 32'd150, 32'd145});
        tick();
        a_re = 1'b0;
        tick();

        // Same-cycle bypass
        a_we = 1'b1; a_wa = 3'd3; a_wv = 16'd7; tick();
        a_wv = 16'd99; a_re = 1'b1; a_s1 = 3'd3; a_s2 = 3'd3; a_s3 = 3'd3;
        qa.push_back('{32'd99, 32'd99, 32'd99});
        tick();
        a_we = 1'b0;
        qa.push_back('{32'd99, 32'd99, 32'd99});
        tick();
        a_re = 1'b0;

        // Lock r4, stalled reads, then clearing write with bypass
        a_le = 1'b1; a_la = 3'd4; tick();
        a_le = 1'b0;
        chk("a_lock_busy4", {31'h0, a_busy[4]}, 32'h1);
        a_re = 1'b1; a_s1 = 3'd0; a_s2 = 3'd4; a_s3 = 3'd0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("a_lock_stall", {31'h0, a_st}, 32'h1);
            tick();
            chk("a_lock_rv", {31'h0, a_rv}, 32'h0);
            chk("a_lock_hold2", {16'h0, a_o2}, 32'd99);
        end
        a_we = 1'b1; a_wa = 3'd4; a_wv = 16'h1234;
        settle();
        chk("a_release_stall", {31'h0, a_st}, 32'h0);
        qa.push_back('{32'd144, 32'h1234, 32'd144});
        tick();
        a_we = 1'b0; a_re = 1'b0;
        chk("a_release_busy4", {31'h0, a_busy[4]}, 32'h0);

        // Lock and write to the same register: lock wins
        a_le = 1'b1; a_la = 3'd5; a_we = 1'b1; a_wa = 3'd5; a_wv = 16'd77;
        tick();
        a_le = 1'b0; a_we = 1'b0;
        chk("a_lockwrite_busy5", {31'h0, a_busy[5]}, 32'h1);
        a_re = 1'b1; a_s1 = 3'd5; a_s2 = 3'd5; a_s3 = 3'd5;
        settle();
        chk("a_lockwrite_stall", {31'h0, a_st}, 32'h1);
        tick();
        a_re = 1'b0;

        // clr beats a same-cycle write; outputs held, rd_valid low
        a_clr = 1'b1; a_we = 1'b1; a_wa = 3'd6; a_wv = 16'd55;
        tick();
        a_clr = 1'b0; a_we = 1'b0;
        chk("a_clr_busy", {24'h0, a_busy}, 32'h0);
        chk("a_clr_rv", {31'h0, a_rv}, 32'h0);
        chk("a_clr_hold1", {16'h0, a_o1}, 32'd144);
        a_re = 1'b1; a_s1 = 3'd6; a_s2 = 3'd1; a_s3 = 3'd5;
        settle();
        chk("a_clr_stall", {31'h0, a_st}, 32'h0);
        qa.push_back('{32'd0, 32'd0, 32'd0});
        tick();
        a_re = 1'b0;

        // Load non-zero outputs, then reset in the middle of a stall
        a_we = 1'b1; a_wa = 3'd7; a_wv = 16'h55AA; tick();
        a_we = 1'b0; a_re = 1'b1; a_s1 = 3'd7; a_s2 = 3'd7; a_s3 = 3'd7;
        qa.push_back('{32'h55AA, 32'h55AA, 32'h55AA});
        tick();
        a_re = 1'b0;
        a_le = 1'b1; a_la = 3'd4; tick();
        a_le = 1'b0;
        a_re = 1'b1; a_s1 = 3'd4; a_s2 = 3'd4; a_s3 = 3'd4;
        settle();
        chk("a_pre_rst_stall", {31'h0, a_st}, 32'h1);
        tick();
        #2;
        a_rst = 1'b0;
        #1;
        chk("a_rst_out1", {16'h0, a_o1}, 32'h0);
        chk("a_rst_out2", {16'h0, a_o2}, 32'h0);
        chk("a_rst_out3", {16'h0, a_o3}, 32'h0);
        chk("a_rst_rv", {31'h0, a_rv}, 32'h0);
        chk("a_rst_busy", {24'h0, a_busy}, 32'h0);
        chk("a_rst_stall", {31'h0, a_st}, 32'h0);
        tick(); tick();
        qa.push_back('{32'd0, 32'd0, 32'd0});
        a_rst = 1'b1;
        tick();
        a_re = 1'b0;
        tick();

        // Wide configuration
        b_we = 1'b1; b_wa = 4'd15; b_wv = 32'hDEADBEEF; tick();
        b_we = 1'b0;
        b_re = 1'b1; b_s1 = 4'd15; b_s2 = 4'd0; b_s3 = 4'd15;
        qb.push_back('{32'hDEADBEEF, 32'd0, 32'hDEADBEEF});
        tick();
        b_re = 1'b0;
        b_le = 1'b1; b_la = 4'd15; tick();
        b_le = 1'b0;
        chk("b_lock_busy", {16'h0, b_busy}, 32'h8000);
        b_re = 1'b1; b_s1 = 4'd15; b_s2 = 4'd15; b_s3 = 4'd15;
        settle();
        chk("b_lock_stall", {31'h0, b_st}, 32'h1);
        tick();
        chk("b_lock_hold1", b_o1, 32'hDEADBEEF);
        #2;
        b_rst = 1'b0;
        #1;
        chk("b_rst_out1", b_o1, 32'h0);
        chk("b_rst_out3", b_o3, 32'h0);
        chk("b_rst_rv", {31'h0, b_rv}, 32'h0);
        chk("b_rst_busy", {16'h0, b_busy}, 32'h0);
        chk("b_rst_stall", {31'h0, b_st}, 32'h0);
        tick();
        qb.push_back('{32'd0, 32'd0, 32'd0});
        b_rst = 1'b1;
        tick();
        b_re = 1'b0;
        tick(); tick();

        chk("a_queue_drained", qa.size(), 32'h0);
        chk("b_queue_drained", qb.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_bank_sb.md
# reg_bank_sb

Parametrised register bank for the RSA ASIP datapath, successor to the fixed 8×16 bank. Provides one write port and three registered read ports (src1, src2, srcdest) with same-cycle write-to-read bypass, plus a per-register busy scoreboard so the decode stage can detect read-after-write hazards against in-flight multi-cycle operations (modular multiply/exponent). Sits between decode and execute.

## Interface
- ARQ, 16, data width in bits (≥8)
- REGS, 8, number of registers (power of two, ≥2)
- AW, $clog2(REGS), register address width (derived, not overridden)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear: all registers and busy bits to 0
- write_en  in  1  write strobe
- write_addr  in  AW  destination register
- write_val  in  ARQ  write data
- lock_en  in  1  mark lock_addr busy (producer issued)
- lock_addr  in  AW  register to lock
- read_en  in  1  read request
- src1, src2, srcdest  in  AW  read addresses
- out1, out2, out3  out  ARQ  registered read data for src1/src2/srcdest
- rd_valid  out  1  outputs updated by an accepted read in the previous cycle
- stall  out  1  combinational: current read request cannot be accepted
- busy  out  REGS  scoreboard bit per register

## Operation
- Write: write_en at edge stores write_val into reg[write_addr]; also clears busy[write_addr].
- Lock: lock_en at edge sets busy[lock_addr]. Lock and write to same address same cycle: busy ends set (new producer wins); data still written.
- Hazard: register r is "pending" if busy[r]=1 and not (write_en and write_addr==r) this cycle.
- stall = read_en and (pending(src1) or pending(src2) or pending(srcdest)).
- Accepted read (read_en and not stall): out1/out2/out3 capture data at edge; rd_valid=1 next cycle.
- Bypass: if write_en and write_addr equals a source address in the accepting cycle, that output captures write_val, not the old contents.
- Not accepted (read_en=0 or stall=1): out1..3 hold previous values; rd_valid=0 next cycle.
- Duplicate source addresses legal; each port returns the same value.
- clr has priority over write and lock in the same cycle; clr does not alter out1..3, rd_valid goes 0.
- No address range checks needed (REGS is power of two).

## Timing
- Reset (rst=0, asynchronous): all registers 0, busy 0, out1..3 0, rd_valid 0. Deassertion takes effect at next edge; a read_en held through reset is accepted on the first edge after release.
- Write-to-read latency: 0 via bypass (same cycle), data visible at outputs 1 cycle after edge.
- Read latency: 1 cycle from accepted request to out/rd_valid.
- Lock-to-stall: lock at edge N → read of that register stalls from cycle N+1 until the cycle containing the clearing write (that cycle is accepted with bypass).
- stall is purely combinational from read_en, addresses, busy, write_en, write_addr; no path from outputs.
- Reset mid-lock: busy cleared, pending reads no longer stall.

## Structure
- Package rsa_regbank_pkg: default ARQ, REGS, reg address type, data word type.
- Sub-module reg_scoreboard: busy vector, lock/clear/clr update, pending evaluation for three addresses, stall output.
- Storage array, bypass muxes and output registers stay in reg_bank_sb.

## Test plan
- Reset then writes r1=150, r0=144, r2=145 (one per cycle), read src1=0, src2=1, srcdest=2 → next cycle out1=144, out2=150, out3=145, rd_valid=1.
- Same-cycle bypass: r3=7 stored, write r3=99 and read src1=3 in same cycle → out1=99; read without write next → out1=99.
- Lock r4, read src2=4 for 3 cycles → stall=1, outputs held, rd_valid=0; write r4=0x1234 in 4th cycle with read → stall=0, out2=0x1234, busy[4]=0.
- Lock and write r5 same cycle → busy[5]=1 after edge; subsequent read src1=5 stalls.
- clr with write_en to r6=55 same cycle → r6=0, all busy 0, rd_valid=0; then read src1=6 → out1=0.
- Assert rst mid-stall (r4 locked, read_en=1) → immediately out1..3=0, busy=0, rd_valid=0; after release read accepted on first edge; repeat with ARQ=32, REGS=16 writing r15=0xDEADBEEF.
